// File: rtl/ariane_pkg.sv
// Store-buffer types, default depths and the page-offset compare helper.
package ariane_pkg;
  localparam int unsigned DEPTH_SPEC   = 4;
  localparam int unsigned DEPTH_COMMIT = 8;

  typedef struct packed {
    logic [riscv::PLEN-1:0]   paddr;
    logic [riscv::XLEN-1:0]   data;
    logic [riscv::XLEN/8-1:0] be;
    logic [1:0]               size;
  } st_entry_t;

  typedef enum logic {
    DRAIN_IDLE = 1'b0,
    DRAIN_REQ  = 1'b1
  } drain_state_e;

  // Double-word granularity: bits [11:3] of the page offset.
  function automatic logic offset_hit(input logic [8:0] stored, input logic [8:0] probe);
    return stored == probe;
  endfunction
endpackage

// File: rtl/riscv.sv
// RISC-V address and data widths shared by the LSU-side blocks.
package riscv;
  localparam int unsigned PLEN = 56;
  localparam int unsigned XLEN = 64;
endpackage

// File: rtl/commit_store_queue_checker.sv
// Protocol checks on the commit interface of the store queue.
module commit_store_queue_checker #(
  parameter int unsigned CW = 3
) (
  input logic          clk,
  input logic          rst,
  input logic          commit,
  input logic [CW-1:0] spec_count,
  input logic          commit_full
);
  commit_needs_entry: assert property (@(posedge clk) disable iff (rst) commit |-> spec_count != '0);
  commit_needs_room:  assert property (@(posedge clk) disable iff (rst) commit |-> !commit_full);
endmodule

// File: rtl/st_queue.sv
// Circular FIFO of store entries exposing occupancy and a per-slot valid view.
module st_queue
  import ariane_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    push,
  input  st_entry_t               push_data,
  input  logic                    pop,
  output st_entry_t               head,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty,
  output logic [DEPTH-1:0]        valid,
  output logic [DEPTH-1:0][8:0]   offsets
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [CW-1:0]         cnt;
  st_entry_t [DEPTH-1:0] mem;

  // A pop coinciding with flush still hands out the head, since head is read combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      valid[i]   = {1'b0, PW'(i) - rd_ptr} < cnt;
      offsets[i] = mem[i].paddr[11:3];
    end
  end

  assign head  = mem[rd_ptr];
  assign count = cnt;
  assign full  = cnt == CW'(DEPTH);
  assign empty = cnt == '0;
endmodule

// File: rtl/commit_store_queue.sv
// Speculative + committed store buffer draining committed stores to the D$ write port.
module commit_store_queue
  import ariane_pkg::*;
#(
  parameter int unsigned SPEC_DEPTH   = DEPTH_SPEC,
  parameter int unsigned COMMIT_DEPTH = DEPTH_COMMIT
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     valid_i,
  input  logic [riscv::PLEN-1:0]   paddr_i,
  input  logic [riscv::XLEN-1:0]   data_i,
  input  logic [riscv::XLEN/8-1:0] be_i,
  input  logic [1:0]               size_i,
  output logic                     ready_o,
  input  logic                     commit_i,
  output logic                     commit_ready_o,
  output logic                     no_st_pending_o,
  input  logic [11:0]              page_offset_i,
  output logic                     page_offset_match_o,
  output logic                     req_o,
  output logic [riscv::PLEN-1:0]   addr_o,
  output logic [riscv::XLEN-1:0]   wdata_o,
  output logic [riscv::XLEN/8-1:0] be_o,
  output logic [1:0]               size_o,
  input  logic                     gnt_i
);
  localparam int unsigned SCW = $clog2(SPEC_DEPTH) + 1;
  localparam int unsigned CCW = $clog2(COMMIT_DEPTH) + 1;

  st_entry_t                    in_entry, spec_head, com_head;
  logic [SCW-1:0]               spec_count;
  logic [CCW-1:0]               com_count;
  logic                         spec_full, spec_empty, com_full, com_empty;
  logic [SPEC_DEPTH-1:0]        spec_valid;
  logic [SPEC_DEPTH-1:0][8:0]   spec_offs;
  logic [COMMIT_DEPTH-1:0]      com_valid;
  logic [COMMIT_DEPTH-1:0][8:0] com_offs;
  logic                         spec_push, promote, drain;
  drain_state_e                 state, state_next;
  logic                         unused_offset_bits;

  assign in_entry  = '{paddr: paddr_i, data: data_i, be: be_i, size: size_i};
  assign spec_push = valid_i && ready_o && !flush_i;
  assign promote   = commit_i && !spec_empty && !com_full;
  assign drain     = req_o && gnt_i;

  st_queue #(.DEPTH(SPEC_DEPTH)) u_spec (
    .clk(clk_i), .rst(rst_i), .flush(flush_i), .push(spec_push), .push_data(in_entry),
    .pop(promote), .head(spec_head), .count(spec_count), .full(spec_full),
    .empty(spec_empty), .valid(spec_valid), .offsets(spec_offs)
  );

  st_queue #(.DEPTH(COMMIT_DEPTH)) u_commit (
    .clk(clk_i), .rst(rst_i), .flush(1'b0), .push(promote), .push_data(spec_head),
    .pop(drain), .head(com_head), .count(com_count), .full(com_full),
    .empty(com_empty), .valid(com_valid), .offsets(com_offs)
  );

  commit_store_queue_checker #(.CW(SCW)) u_chk (
    .clk(clk_i), .rst(rst_i), .commit(commit_i), .spec_count(spec_count), .commit_full(com_full)
  );

  // Drain FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= DRAIN_IDLE;
    else       state <= state_next;
  end

  // A same-cycle promotion counts toward the next occupancy so req rises one cycle after commit.
  always_comb begin
    state_next = state;
    case (state)
      DRAIN_IDLE: begin
        if (!com_empty || promote) state_next = DRAIN_REQ;
        else                       state_next = DRAIN_IDLE;
      end
      DRAIN_REQ: begin
        if (gnt_i && com_count == CCW'(1) && !promote) state_next = DRAIN_IDLE;
        else                                           state_next = DRAIN_REQ;
      end
      default: state_next = DRAIN_IDLE;
    endcase
  end

  assign req_o           = state == DRAIN_REQ;
  assign addr_o          = req_o ? com_head.paddr : '0;
  assign wdata_o         = req_o ? com_head.data  : '0;
  assign be_o            = req_o ? com_head.be    : '0;
  assign size_o          = req_o ? com_head.size  : 2'b00;
  assign ready_o         = !spec_full;
  assign commit_ready_o  = !com_full;
  assign no_st_pending_o = com_empty && state == DRAIN_IDLE;

  // Load hazard: any buffered store or the incoming one on the same double word.
  always_comb begin
    page_offset_match_o = valid_i && offset_hit(paddr_i[11:3], page_offset_i[11:3]);
    for (int i = 0; i < int'(SPEC_DEPTH); i++) begin
      page_offset_match_o = page_offset_match_o |
                            (spec_valid[i] && offset_hit(spec_offs[i], page_offset_i[11:3]));
    end
    for (int i = 0; i < int'(COMMIT_DEPTH); i++) begin
      page_offset_match_o = page_offset_match_o |
                            (com_valid[i] && offset_hit(com_offs[i], page_offset_i[11:3]));
    end
  end

  assign unused_offset_bits = ^page_offset_i[2:0];
endmodule

// File: tb/tb_commit_store_queue.sv
// Directed self-checking bench for commit_store_queue.
module tb_commit_store_queue;
  logic                     clk = 1'b0;
  logic                     rst_i, flush_i, valid_i, commit_i, gnt_i;
  logic [riscv::PLEN-1:0]   paddr_i, addr_o;
  logic [riscv::XLEN-1:0]   data_i, wdata_o;
  logic [riscv::XLEN/8-1:0] be_i, be_o;
  logic [1:0]               size_i, size_o;
  logic [11:0]              page_offset_i;
  logic                     ready_o, commit_ready_o, no_st_pending_o, page_offset_match_o, req_o;
  int                       n_checks = 0;
  int                       n_fail = 0;

  always #5 clk = ~clk;

  commit_store_queue dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i), .paddr_i(paddr_i),
    .data_i(data_i), .be_i(be_i), .size_i(size_i), .ready_o(ready_o), .commit_i(commit_i),
    .commit_ready_o(commit_ready_o), .no_st_pending_o(no_st_pending_o),
    .page_offset_i(page_offset_i), .page_offset_match_o(page_offset_match_o),
    .req_o(req_o), .addr_o(addr_o), .wdata_o(wdata_o), .be_o(be_o), .size_o(size_o),
    .gnt_i(gnt_i)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; flush_i = 1'b0; valid_i = 1'b0; commit_i = 1'b0; gnt_i = 1'b0;
    paddr_i = '0; data_i = '0; be_i = 8'hFF; size_i = 2'b11; page_offset_i = 12'h000;
    tick(); tick();
    rst_i = 1'b0;
    n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", ready_o); end
    n_checks++; if (commit_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_commit_ready: got %b want 1", commit_ready_o); end
    n_checks++; if (no_st_pending_o !== 1'b1) begin n_fail++; $display("FAIL reset_no_st_pending: got %b want 1", no_st_pending_o); end
    n_checks++; if (req_o !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", req_o); end
    n_checks++; if ({addr_o, wdata_o, be_o, size_o} !== '0) begin n_fail++; $display("FAIL reset_outputs: got addr %h data %h be %h size %h want 0", addr_o, wdata_o, be_o, size_o); end
  endtask

  task automatic test_fill_spec();
    for (int i = 0; i < 4; i++) begin
      valid_i = 1'b1; paddr_i = 56'h1000 + 56'(i * 8); data_i = 64'(i);
      tick();
      if (i == 2) begin
        n_checks++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL spec_ready_at3: got %b want 1", ready_o); end
      end
    end
    n_checks++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL spec_full_ready: got %b want 0", ready_o); end
    paddr_i = 56'h2000;
    tick();
    valid_i = 1'b0;
    n_checks++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL spec_fifth_ready: got %b want 0", ready_o); end
    n_checks++; if (req_o !== 1'b0) begin n_fail++; $display("FAIL spec_no_req: got %b want 0", req_o); end
    n_checks++; if (no_st_pending_o !== 1'b1) begin n_fail++; $display("FAIL spec_no_st_pending: got %b want 1", no_st_pending_o); end
    commit_i = 1'b1;
    tick(); tick(); tick(); tick();
    commit_i = 1'b0;
    gnt_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (req_o !== 1'b1 || addr_o !== 56'h1000 + 56'(i * 8)) begin n_fail++; $display("FAIL spec_drain_%0d: got req %b addr %h want req 1 addr %h", i, req_o, addr_o, 56'h1000 + 56'(i * 8)); end
      tick();
    end
    gnt_i = 1'b0;
    n_checks++; if (req_o !== 1'b0 || no_st_pending_o !== 1'b1) begin n_fail++; $display("FAIL spec_fifth_dropped: got req %b nsp %b want req 0 nsp 1", req_o, no_st_pending_o); end
  endtask

  task automatic test_single_store();
    valid_i = 1'b1; paddr_i = 56'h8000_1008; data_i = 64'hDEAD_BEEF; be_i = 8'h0F; size_i = 2'b10;
    tick();
    valid_i = 1'b0; be_i = 8'hFF; size_i = 2'b11;
    n_checks++; if (req_o !== 1'b0 || no_st_pending_o !== 1'b1) begin n_fail++; $display("FAIL single_uncommitted: got req %b nsp %b want req 0 nsp 1", req_o, no_st_pending_o); end
    commit_i = 1'b1;
    tick();
    commit_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (req_o !== 1'b1 || addr_o !== 56'h8000_1008 || wdata_o !== 64'hDEAD_BEEF || be_o !== 8'h0F || size_o !== 2'b10) begin
        n_fail++; $display("FAIL single_req_cyc%0d: got req %b addr %h data %h be %h size %b want 1 80001008 deadbeef 0f 10", i, req_o, addr_o, wdata_o, be_o, size_o);
      end
      if (i < 3) tick();
    end
    n_checks++; if (no_st_pending_o !== 1'b0) begin n_fail++; $display("FAIL single_pending: got %b want 0", no_st_pending_o); end
    gnt_i = 1'b1;
    tick();
    gnt_i = 1'b0;
    n_checks++; if (no_st_pending_o !== 1'b1 || req_o !== 1'b0) begin n_fail++; $display("FAIL single_done: got nsp %b req %b want nsp 1 req 0", no_st_pending_o, req_o); end
  endtask

  task automatic test_fill_commit();
    for (int i = 0; i < 9; i++) begin
      valid_i = (i < 8); commit_i = (i > 0);
      paddr_i = 56'h3000 + 56'(i * 64); data_i = 64'hA000_0000 + 64'(i);
      if (i == 8) begin
        n_checks++; if (commit_ready_o !== 1'b1) begin n_fail++; $display("FAIL commit_ready_at7: got %b want 1", commit_ready_o); end
      end
      tick();
    end
    valid_i = 1'b0; commit_i = 1'b0;
    n_checks++; if (commit_ready_o !== 1'b0) begin n_fail++; $display("FAIL commit_full: got %b want 0", commit_ready_o); end
    gnt_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (req_o !== 1'b1 || addr_o !== 56'h3000 + 56'(i * 64) || wdata_o !== 64'hA000_0000 + 64'(i)) begin
        n_fail++; $display("FAIL b2b_drain_%0d: got req %b addr %h data %h want req 1 addr %h data %h", i, req_o, addr_o, wdata_o, 56'h3000 + 56'(i * 64), 64'hA000_0000 + 64'(i));
      end
      tick();
      if (i == 0) begin
        n_checks++; if (commit_ready_o !== 1'b1) begin n_fail++; $display("FAIL commit_ready_after_gnt: got %b want 1", commit_ready_o); end
      end
    end
    gnt_i = 1'b0;
    n_checks++; if (req_o !== 1'b0 || no_st_pending_o !== 1'b1) begin n_fail++; $display("FAIL b2b_done: got req %b nsp %b want req 0 nsp 1", req_o, no_st_pending_o); end
  endtask

  task automatic test_flush_commit();
    valid_i = 1'b1; paddr_i = 56'h4000; data_i = 64'h11;
    tick();
    paddr_i = 56'h4008; data_i = 64'h22;
    tick();
    valid_i = 1'b0; page_offset_i = 12'h008;
    #1;
    n_checks++; if (page_offset_match_o !== 1'b1) begin n_fail++; $display("FAIL flush_pre_match: got %b want 1", page_offset_match_o); end
    commit_i = 1'b1; flush_i = 1'b1;
    tick();
    commit_i = 1'b0; flush_i = 1'b0;
    n_checks++; if (req_o !== 1'b1 || addr_o !== 56'h4000 || wdata_o !== 64'h11) begin n_fail++; $display("FAIL flush_survivor: got req %b addr %h data %h want 1 4000 11", req_o, addr_o, wdata_o); end
    n_checks++; if (page_offset_match_o !== 1'b0) begin n_fail++; $display("FAIL flush_spec_empty: got %b want 0", page_offset_match_o); end
    gnt_i = 1'b1;
    tick();
    gnt_i = 1'b0;
    tick();
    n_checks++; if (req_o !== 1'b0 || no_st_pending_o !== 1'b1) begin n_fail++; $display("FAIL flush_one_store: got req %b nsp %b want req 0 nsp 1", req_o, no_st_pending_o); end
    page_offset_i = 12'h000;
  endtask

  task automatic test_page_offset();
    valid_i = 1'b1; paddr_i = 56'h1238; data_i = 64'h33;
    tick();
    valid_i = 1'b0; page_offset_i = 12'h23C;
    #1;
    n_checks++; if (page_offset_match_o !== 1'b1) begin n_fail++; $display("FAIL off_spec_hit: got %b want 1", page_offset_match_o); end
    page_offset_i = 12'h240;
    #1;
    n_checks++; if (page_offset_match_o !== 1'b0) begin n_fail++; $display("FAIL off_spec_miss: got %b want 0", page_offset_match_o); end
    valid_i = 1'b1; paddr_i = 56'h5240;
    #1;
    n_checks++; if (page_offset_match_o !== 1'b1) begin n_fail++; $display("FAIL off_incoming_hit: got %b want 1", page_offset_match_o); end
    valid_i = 1'b0;
    commit_i = 1'b1;
    tick();
    commit_i = 1'b0; page_offset_i = 12'h23C;
    #1;
    n_checks++; if (page_offset_match_o !== 1'b1 || req_o !== 1'b1) begin n_fail++; $display("FAIL off_committed_hit: got match %b req %b want 1 1", page_offset_match_o, req_o); end
    gnt_i = 1'b1;
    tick();
    gnt_i = 1'b0;
    n_checks++; if (page_offset_match_o !== 1'b0) begin n_fail++; $display("FAIL off_drained: got %b want 0", page_offset_match_o); end
  endtask

  task automatic test_reset_mid();
    valid_i = 1'b1; paddr_i = 56'h5000; data_i = 64'h44;
    tick();
    paddr_i = 56'h5008; commit_i = 1'b1;
    tick();
    valid_i = 1'b0; commit_i = 1'b0;
    n_checks++; if (req_o !== 1'b1 || addr_o !== 56'h5000) begin n_fail++; $display("FAIL mid_req: got req %b addr %h want 1 5000", req_o, addr_o); end
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    n_checks++; if (req_o !== 1'b0 || {addr_o, wdata_o, be_o, size_o} !== '0) begin n_fail++; $display("FAIL mid_rst_outputs: got req %b addr %h data %h want 0", req_o, addr_o, wdata_o); end
    n_checks++; if (ready_o !== 1'b1 || commit_ready_o !== 1'b1 || no_st_pending_o !== 1'b1) begin n_fail++; $display("FAIL mid_rst_flags: got rdy %b crdy %b nsp %b want 1 1 1", ready_o, commit_ready_o, no_st_pending_o); end
    page_offset_i = 12'h008;
    #1;
    n_checks++; if (page_offset_match_o !== 1'b0) begin n_fail++; $display("FAIL mid_rst_spec_empty: got %b want 0", page_offset_match_o); end
    tick(); tick();
    n_checks++; if (req_o !== 1'b0) begin n_fail++; $display("FAIL mid_rst_stays_idle: got %b want 0", req_o); end
  endtask

  initial begin
    test_reset();
    test_fill_spec();
    test_single_store();
    test_fill_commit();
    test_flush_commit();
    test_page_offset();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/commit_store_queue.md
# commit_store_queue

Two-level store buffer directly downstream of the commit stage: it holds speculative stores from the LSU, promotes the oldest one to a committed queue when commit asserts `commit_lsu`, and drains committed stores to the data-cache write port through a req/gnt handshake. It supplies the commit stage with `commit_lsu_ready` and `no_st_pending`, which gate store, FENCE, FENCE.I, FENCE.T and SFENCE.VMA retirement. It also reports page-offset hazards to the load unit.

## Interface
- `SPEC_DEPTH`, default 4: number of speculative entries; power of two, ≥2.
- `COMMIT_DEPTH`, default 8: number of committed entries; power of two, ≥2.
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `flush_i` in 1: discard all speculative entries.
- `valid_i` in 1: new speculative store.
- `paddr_i` in riscv::PLEN: physical address.
- `data_i` in riscv::XLEN: store data.
- `be_i` in XLEN/8: byte enables.
- `size_i` in 2: access size.
- `ready_o` out 1: speculative queue can accept an entry.
- `commit_i` in 1: promote the oldest speculative entry (from commit `commit_lsu_o`).
- `commit_ready_o` out 1: committed queue can accept a promotion.
- `no_st_pending_o` out 1: committed queue empty and no request in flight.
- `page_offset_i` in 12: load page offset to check.
- `page_offset_match_o` out 1: a buffered or incoming store overlaps this offset.
- `req_o` out 1: D$ write request.
- `addr_o` out riscv::PLEN: request address.
- `wdata_o` out riscv::XLEN: request data.
- `be_o` out XLEN/8: request byte enables.
- `size_o` out 2: request size.
- `gnt_i` in 1: D$ accepted the request.

## Operation
- Speculative queue: a circular FIFO with read/write pointers and a count. It is written when `valid_i && ready_o && !flush_i`.
- Promotion: when `commit_i` is high and the speculative queue is non-empty, the head entry moves to the committed tail in the same cycle; speculative read pointer +1, committed write pointer +1.
- `commit_i` with the speculative queue empty is a protocol error. The block ignores it and the assertion fires.
- `commit_i` while `commit_ready_o=0` is a protocol error. The block ignores it and the assertion fires.
- Flush: `flush_i` resets the speculative pointers and count to 0.
  - A simultaneous `commit_i` is honoured first, so the promoted entry survives.
  - A simultaneous `valid_i` is dropped.
- Committed queue drain uses a two-state FSM.
  - IDLE: `req_o=0`. Moves to REQ when the committed count is > 0.
  - REQ: `req_o=1`; `addr_o`, `wdata_o`, `be_o` and `size_o` are driven from the head entry and stay stable until grant.
  - On `gnt_i` in REQ: pop the head. Stay in REQ if count after the pop is > 0, otherwise go to IDLE.
  - `flush_i` never affects the committed queue or the FSM.
- `no_st_pending_o` = (committed count == 0) && state == IDLE.
- `page_offset_match_o` is combinational. It is set when `page_offset_i[11:3]` equals `paddr[11:3]` of any of:
  - any valid speculative entry;
  - any valid committed entry;
  - the incoming `paddr_i` while `valid_i` is high.
- Pointers wrap modulo depth. Counts are log2(depth)+1 bits wide, so a full queue is distinguishable from an empty one.

## Timing
- Reset values: `ready_o=1`, `commit_ready_o=1`, `no_st_pending_o=1`, `req_o=0`, address/data/be/size outputs 0, FSM in IDLE, all counts 0.
- `ready_o` = speculative count < SPEC_DEPTH, taken from the registered count. A promotion in the same cycle does not raise `ready_o` until the next cycle.
- `commit_ready_o` = committed count < COMMIT_DEPTH, from the registered count. A same-cycle grant does not raise it until the next cycle.
- Latency:
  - store written in cycle N → promotable in N+1;
  - promoted in cycle N → `req_o` rises in N+1;
  - granted in cycle N → next entry presented in N+1 (back-to-back, no bubble).
- Simultaneous push+promote on the speculative queue and simultaneous promote+grant on the committed queue are both legal. Each count changes by the net amount.
- Reset mid-request drops all entries; `req_o` is low the cycle after `rst_i` is sampled.

## Structure
- `st_entry_t` {paddr, data, be, size} goes in `ariane_pkg`.
- `DEPTH_SPEC` and `DEPTH_COMMIT` constants go in `ariane_pkg`; the top-level parameters default to them.
- One sub-module, `st_queue`: a parameterised circular FIFO of `st_entry_t` with push/pop, count, full/empty and an entry-valid vector for the offset compare. It is instantiated twice; the drain FSM and offset compare sit at top level.

## Test plan
- Push 4 stores with no commits → `ready_o` drops after the 4th; a 5th `valid_i` is ignored; `req_o` stays 0; `no_st_pending_o=1`.
- Push `0x80001008`/`0xDEADBEEF`/be `0x0F`, commit the next cycle → `req_o=1` in the following cycle with those exact values. Hold `gnt_i=0` for 3 cycles → outputs stable. After `gnt_i`, `no_st_pending_o` reaches 1 one cycle later.
- Fill the committed queue to 8 with `gnt_i=0` → `commit_ready_o=0`. Then hold `gnt_i=1` → one store per cycle, in FIFO order, through pointer wrap.
- Two speculative stores, `commit_i` and `flush_i` in the same cycle → exactly one store reaches the D$; speculative count is 0.
- Store at `paddr 0x1238` buffered, `page_offset_i=0x23C` → `page_offset_match_o=1`. With `0x240` → 0. After the store drains with `0x23C` → 0.
- Assert `rst_i` while `req_o=1` → next cycle all outputs at reset values and queues empty.
